// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store front-end for a byte-masked 32-bit word memory.
// Takes one byte-addressed request at a time, checks alignment, drives a
// single-cycle memory access and returns an extended response.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid/req_ready         request handshake (ready only when idle)
//   req_we, req_size,           store flag, size (0 byte, 1 half, 2 word,
//   req_unsigned                3 illegal), zero-extend loads
//   req_addr, req_wdata         byte address, right-justified store data
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata, rsp_err          extended load data, misalign/illegal flag
//   mem_en, mem_wr, mem_wr_mask memory strobe, write, byte-lane mask
//   mem_addr, mem_wr_data       word address, lane-replicated write data
//   mem_r_data                  registered read data (valid one cycle after read)
module lsu_mem_ctrl #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRESS   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [ADDRESS+1:0]   req_addr,
  input  logic [DATAWIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATAWIDTH-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 mem_en,
  output logic                 mem_wr,
  output logic [3:0]           mem_wr_mask,
  output logic [ADDRESS-1:0]   mem_addr,
  output logic [DATAWIDTH-1:0] mem_wr_data,
  input  logic [DATAWIDTH-1:0] mem_r_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} state_t;

  state_t               state, state_n;
  logic                 mem_en_n, mem_wr_n;
  logic [3:0]           mask_n;
  logic [ADDRESS-1:0]   addr_n;
  logic [DATAWIDTH-1:0] wdata_n, rdata_n;
  logic                 err_n;
  // Request attributes kept for load-lane extraction in RD_WAIT.
  logic [1:0]           lo_q, lo_n, size_q, size_n;
  logic                 uns_q, uns_n;

  logic                 misaligned;
  logic [7:0]           rd_byte;
  logic [15:0]          rd_half;
  logic [DATAWIDTH-1:0] rd_ext;

  assign misaligned = (req_size == 2'd3) ||
                      (req_size == 2'd1 && req_addr[0]) ||
                      (req_size == 2'd2 && req_addr[1:0] != 2'b00);

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Lane select from the word returned by the memory.
  always_comb begin
    rd_byte = mem_r_data[{lo_q, 3'b000} +: 8];
    rd_half = lo_q[1] ? mem_r_data[31:16] : mem_r_data[15:0];
    case (size_q)
      2'd0:    rd_ext = {{24{~uns_q & rd_byte[7]}}, rd_byte};
      2'd1:    rd_ext = {{16{~uns_q & rd_half[15]}}, rd_half};
      default: rd_ext = mem_r_data;
    endcase
  end

  always_comb begin
    state_n  = state;
    mem_en_n = 1'b0;
    mem_wr_n = 1'b0;
    mask_n   = 4'b0000;
    addr_n   = mem_addr;
    wdata_n  = mem_wr_data;
    rdata_n  = rsp_rdata;
    err_n    = rsp_err;
    lo_n     = lo_q;
    size_n   = size_q;
    uns_n    = uns_q;
    case (state)
      IDLE: if (req_valid) begin
        lo_n   = req_addr[1:0];
        size_n = req_size;
        uns_n  = req_unsigned;
        if (misaligned) begin
          state_n = RESP;
          err_n   = 1'b1;
          rdata_n = '0;
        end else begin
          state_n  = ISSUE;
          mem_en_n = 1'b1;
          mem_wr_n = req_we;
          addr_n   = req_addr[ADDRESS+1:2];
          if (req_we) begin
            case (req_size)
              2'd0: begin
                mask_n  = 4'b0001 << req_addr[1:0];
                wdata_n = {4{req_wdata[7:0]}};
              end
              2'd1: begin
                mask_n  = 4'b0011 << req_addr[1:0];
                wdata_n = {2{req_wdata[15:0]}};
              end
              default: begin
                mask_n  = 4'b1111;
                wdata_n = req_wdata;
              end
            endcase
          end
        end
      end
      ISSUE: begin
        // mem_wr still holds the request's store flag during ISSUE.
        if (mem_wr) begin
          state_n = RESP;
          rdata_n = '0;
          err_n   = 1'b0;
        end else begin
          state_n = RD_WAIT;
        end
      end
      RD_WAIT: begin
        state_n = RESP;
        rdata_n = rd_ext;
        err_n   = 1'b0;
      end
      RESP: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_wr_mask <= 4'b0000;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      lo_q        <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
    end else begin
      state       <= state_n;
      mem_en      <= mem_en_n;
      mem_wr      <= mem_wr_n;
      mem_wr_mask <= mask_n;
      mem_addr    <= addr_n;
      mem_wr_data <= wdata_n;
      rsp_rdata   <= rdata_n;
      rsp_err     <= err_n;
      lo_q        <= lo_n;
      size_q      <= size_n;
      uns_q       <= uns_n;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en, mem_wr;
  logic [3:0]  mem_wr_mask;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wr_data, mem_r_data;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.DATAWIDTH(32), .ADDRESS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_wr_mask(mem_wr_mask),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_r_data(mem_r_data)
  );

  // Behavioural byte-masked memory with a one-cycle registered read port.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr) begin
        for (int b = 0; b < 4; b++)
          if (mem_wr_mask[b]) mem[mem_addr][8*b +: 8] <= mem_wr_data[8*b +: 8];
      end else begin
        mem_r_data <= mem[mem_addr];
      end
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [3:0]  exp_mask;
    logic [7:0]  exp_maddr;
    logic [31:0] exp_mwdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vt[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [9:0] addr,
                              logic [31:0] wdata, logic [31:0] er, logic ee,
                              logic [3:0] em, logic [31:0] ewd);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = er; v.exp_err = ee;
    v.exp_lat = ee ? 1 : (we ? 2 : 3);
    v.exp_mask = em; v.exp_maddr = addr[9:2]; v.exp_mwdata = ewd;
    return v;
  endfunction

  // Drive one request, follow it to its response, optionally hold off
  // rsp_ready for 'hold' cycles, then complete the handshake.
  task automatic run(input vec_t v, input int hold);
    exp_t e;
    int lat, pulses;
    logic [3:0] cmask; logic [7:0] caddr; logic [31:0] cwd; logic cwr;
    logic [31:0] r0; logic e0;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    chk("req_ready_before", {31'd0, req_ready}, 32'd1);
    sb.push_back('{v.exp_rdata, v.exp_err, v.exp_lat});
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; pulses = 0; cmask = 0; caddr = 0; cwd = 0; cwr = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (mem_en) begin
        pulses++; cmask = mem_wr_mask; caddr = mem_addr; cwd = mem_wr_data; cwr = mem_wr;
      end
      if (rsp_valid || lat > 20) break;
    end
    e = sb.pop_front();
    if (!rsp_valid) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    chk("latency", lat, e.lat);
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
    chk("mem_pulses", pulses, v.exp_err ? 0 : 1);
    if (!v.exp_err) begin
      chk("mem_addr", {24'd0, caddr}, {24'd0, v.exp_maddr});
      chk("mem_wr", {31'd0, cwr}, {31'd0, v.we});
      chk("mem_mask", {28'd0, cmask}, {28'd0, v.exp_mask});
      if (v.we) chk("mem_wdata", cwd, v.exp_mwdata);
    end
    r0 = rsp_rdata; e0 = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, r0);
      chk("bp_err", {31'd0, rsp_err}, {31'd0, e0});
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_mem_en", {31'd0, mem_en}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    chk("req_ready_after", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[1] = 32'h80F1_7F22;
    mem_r_data = 32'h0;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; rsp_ready = 0;
    rst_n = 1'b0;

    //        we size uns addr    wdata         exp_rdata     err mask     mem_wdata
    vt.push_back(mk(0, 0, 0, 10'h005, 32'h0,        32'h0000007F, 0, 4'b0000, 32'h0));
    vt.push_back(mk(0, 0, 0, 10'h006, 32'h0,        32'hFFFFFFF1, 0, 4'b0000, 32'h0));
    vt.push_back(mk(0, 1, 1, 10'h006, 32'h0,        32'h000080F1, 0, 4'b0000, 32'h0));
    vt.push_back(mk(0, 1, 0, 10'h006, 32'h0,        32'hFFFF80F1, 0, 4'b0000, 32'h0));
    vt.push_back(mk(0, 0, 1, 10'h007, 32'h0,        32'h00000080, 0, 4'b0000, 32'h0));
    vt.push_back(mk(0, 2, 0, 10'h004, 32'h0,        32'h80F17F22, 0, 4'b0000, 32'h0));
    vt.push_back(mk(1, 0, 0, 10'h006, 32'h000000AB, 32'h0,        0, 4'b0100, 32'hABABABAB));
    vt.push_back(mk(0, 0, 1, 10'h006, 32'h0,        32'h000000AB, 0, 4'b0000, 32'h0));
    vt.push_back(mk(1, 2, 0, 10'h3FC, 32'hDEADBEEF, 32'h0,        0, 4'b1111, 32'hDEADBEEF));
    vt.push_back(mk(0, 2, 0, 10'h3FC, 32'h0,        32'hDEADBEEF, 0, 4'b0000, 32'h0));
    vt.push_back(mk(1, 1, 0, 10'h00A, 32'h12345678, 32'h0,        0, 4'b1100, 32'h56785678));
    vt.push_back(mk(0, 1, 0, 10'h00A, 32'h0,        32'h00005678, 0, 4'b0000, 32'h0));
    vt.push_back(mk(0, 1, 0, 10'h003, 32'h0,        32'h0,        1, 4'b0000, 32'h0));
    vt.push_back(mk(0, 2, 0, 10'h002, 32'h0,        32'h0,        1, 4'b0000, 32'h0));
    vt.push_back(mk(1, 3, 0, 10'h000, 32'h11111111, 32'h0,        1, 4'b0000, 32'h0));

    // Reset state.
    #12;
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mask", {28'd0, mem_wr_mask}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wr_data, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;

    foreach (vt[i]) run(vt[i], 0);

    // Backpressure on a load response, then an immediate follow-on request.
    run(mk(0, 0, 0, 10'h005, 32'h0, 32'h0000007F, 0, 4'b0000, 32'h0), 5);
    run(mk(0, 2, 0, 10'h3FC, 32'h0, 32'hDEADBEEF, 0, 4'b0000, 32'h0), 0);

    // Reset while a load sits in RD_WAIT: the load is dropped silently.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 10'h004;
    @(posedge clk); #1 req_valid = 1'b0;   // accepted, now in ISSUE
    @(posedge clk); #2 rst_n = 1'b0;        // now in RD_WAIT
    #1;
    chk("midrst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("postrst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("postrst_mem_en", {31'd0, mem_en}, 32'd0);
    end
    rsp_ready = 1'b0;
    run(mk(0, 0, 1, 10'h006, 32'h0, 32'h000000AB, 0, 4'b0000, 32'h0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
